// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES job sequencer.
// Holds the FSM state encoding, key-size codes, widths and packed bus structs.
package aes_seq_pkg;

  localparam int BLK_W = 128;
  localparam int KEY_W = 256;

  localparam logic [1:0] KSZ_128 = 2'd0;
  localparam logic [1:0] KSZ_192 = 2'd1;
  localparam logic [1:0] KSZ_256 = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_RUN,
    ST_OUT,
    ST_ERR
  } state_e;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [1:0]       size;
    logic             dec;
    logic             cbc;
  } cfg_t;

  typedef struct packed {
    logic [BLK_W-1:0] dat;
    logic             last;
  } blk_t;

endpackage

// File: rtl/aes_seq_fifo.sv
// Generic DEPTH-entry FIFO; read data is visible combinationally at the head.
// Full refuses pushes (even with a simultaneous pop); empty ignores pops.
module aes_seq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 129
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             push_ok, pop_ok;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + (AW+1)'(1);
      if (pop_ok)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/aes_job_sequencer.sv
// Feeds queued 128-bit blocks to an AES core with ECB/CBC chaining and dual-rail data.
// Latency pop->out_valid is 3 cycles plus core busy time; in_ready_o drops when the queue fills.
module aes_job_sequencer
  import aes_seq_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] cfg_key_i,
  input  logic [1:0]       cfg_size_i,
  input  logic             cfg_dec_i,
  input  logic             cfg_cbc_i,
  input  logic [BLK_W-1:0] cfg_iv_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [BLK_W-1:0] in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [BLK_W-1:0] out_data_o,
  output logic             out_last_o,
  output logic             core_load_o,
  output logic [KEY_W-1:0] core_key_o,
  output logic [BLK_W-1:0] core_data_o,
  output logic [BLK_W-1:0] core_datab_o,
  output logic [1:0]       core_size_o,
  output logic             core_dec_o,
  input  logic             core_busy_i,
  input  logic [BLK_W-1:0] core_data_i,
  output logic             error_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_e           state_q, state_d;
  cfg_t             shd_q, shd_d, cfg_now;
  logic [BLK_W-1:0] chain_q, chain_d;
  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BLK_W-1:0] res_q, res_d;
  logic             last_q, last_d;
  logic             sof_q, sof_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rdy_en_q;

  blk_t             fifo_wdat, fifo_rdat;
  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic             go_load, load;
  logic [BLK_W-1:0] load_x;

  assign cfg_now   = {cfg_key_i, cfg_size_i, cfg_dec_i, cfg_cbc_i};
  assign fifo_wdat = {in_data_i, in_last_i};
  assign fifo_push = in_valid_i && in_ready_o;

  aes_seq_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(blk_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdat),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdat),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shd_q    <= '0;
      chain_q  <= '0;
      blk_q    <= '0;
      res_q    <= '0;
      last_q   <= 1'b0;
      sof_q    <= 1'b1;
      cnt_q    <= '0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      shd_q    <= shd_d;
      chain_q  <= chain_d;
      blk_q    <= blk_d;
      res_q    <= res_d;
      last_q   <= last_d;
      sof_q    <= sof_d;
      cnt_q    <= cnt_d;
      rdy_en_q <= 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    shd_d    = shd_q;
    chain_d  = chain_q;
    blk_d    = blk_q;
    res_d    = res_q;
    last_d   = last_q;
    sof_d    = sof_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    load     = 1'b0;
    go_load  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) go_load = 1'b1;
      end
      ST_LOAD: begin
        load     = 1'b1;
        fifo_pop = 1'b1;
        blk_d    = fifo_rdat.dat;
        last_d   = fifo_rdat.last;
        sof_d    = fifo_rdat.last;
        cnt_d    = '0;
        state_d  = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == CW'(TIMEOUT)) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (core_busy_i) state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CW'(TIMEOUT)) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (!core_busy_i) begin
            state_d = ST_OUT;
            // Decrypt chains on the ciphertext we fed in; encrypt chains on the result.
            if (shd_q.cbc && shd_q.dec) begin
              res_d   = core_data_i ^ chain_q;
              chain_d = blk_q;
            end else begin
              res_d = core_data_i;
              if (shd_q.cbc) chain_d = core_data_i;
            end
          end
        end
      end
      ST_OUT: begin
        if (out_ready_i) begin
          if (!fifo_empty) go_load = 1'b1;
          else             state_d = ST_IDLE;
        end
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Configuration is frozen for the whole message, captured only at its first block.
    if (go_load) begin
      state_d = ST_LOAD;
      if (sof_q) begin
        shd_d   = cfg_now;
        chain_d = cfg_iv_i;
      end
    end
  end

  assign load_x = (shd_q.cbc && !shd_q.dec) ? (fifo_rdat.dat ^ chain_q) : fifo_rdat.dat;

  // Both rails sit at zero outside the load cycle so every load is a full precharge-evaluate.
  assign core_load_o  = load;
  assign core_data_o  = load ? load_x : '0;
  assign core_datab_o = load ? ~load_x : '0;
  assign core_key_o   = shd_q.key;
  assign core_size_o  = shd_q.size;
  assign core_dec_o   = shd_q.dec;

  assign out_valid_o = (state_q == ST_OUT);
  assign out_data_o  = out_valid_o ? res_q : '0;
  assign out_last_o  = out_valid_o && last_q;

  assign in_ready_o = rdy_en_q && !fifo_full && (state_q != ST_ERR);
  assign error_o    = (state_q == ST_ERR);

endmodule

// File: doc/aes_job_sequencer.md
AES_JOB_SEQUENCER -- requirements
Module: aes_job_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the input queue depth in 128-bit blocks (power of 2, at least 2).
REQ-002 SHALL have parameter TIMEOUT, default 64, meaning the maximum number of cycles to wait for the core to respond after core_load_o.
REQ-003 SHALL use one clock and an asynchronous, active-low reset, with ports in this order:
 clk  in  1  clock, all state on rising edge
 rst_n  in  1  asynchronous active-low reset
REQ-004 SHALL have these configuration ports:
 cfg_key_i  in  256  key, MSB-aligned
 cfg_size_i  in  2  key size code; 0=128, 1=192, 2=256
 cfg_dec_i  in  1  1=decrypt
 cfg_cbc_i  in  1  1=CBC chaining, 0=ECB
 cfg_iv_i  in  128  CBC initial vector
REQ-005 SHALL have these upstream ports:
 in_valid_i  in  1  input block valid
 in_ready_o  out  1  input queue not full
 in_data_i  in  128  input block
 in_last_i  in  1  marks the final block of a message
REQ-006 SHALL have these downstream ports:
 out_valid_o  out  1  output block valid
 out_ready_i  in  1  sink accepts the block
 out_data_o  out  128  output block
 out_last_o  out  1  final block of the message
REQ-007 SHALL have these core-side ports:
 core_load_o  out  1  one-cycle load strobe
 core_key_o  out  256  key to the core
 core_data_o  out  128  true-rail data to the core
 core_datab_o  out  128  complement-rail data to the core
 core_size_o  out  2  key size code
 core_dec_o  out  1  decrypt select
 core_busy_i  in  1  core busy
 core_data_i  in  128  core result
REQ-008 SHALL have error_o  out  1, a sticky timeout flag.

Function
REQ-009 Input queue SHALL be a DEPTH-entry FIFO of {data, last}; in_ready_o=1 iff not full; a push occurs when in_valid_i & in_ready_o; a simultaneous push and pop when full SHALL be refused (ready is already low).
REQ-010 FSM states SHALL be IDLE, LOAD, WAIT, RUN, OUT, ERR.
REQ-011 IDLE->LOAD when the FIFO is non-empty; cfg_* SHALL be latched into shadow registers only on the first block of a message (start-of-message flag set at reset and after each popped last block); the chain register SHALL be loaded with cfg_iv_i at that time.
REQ-012 LOAD SHALL last exactly one cycle: core_load_o=1, FIFO pop, core_data_o=X, core_datab_o=~X, where X=block^chain for CBC encrypt and X=block otherwise.
REQ-013 Outside LOAD, core_data_o and core_datab_o SHALL both be 0 (precharge); core_key_o, core_size_o and core_dec_o SHALL hold their shadow values.
REQ-014 WAIT->RUN on core_busy_i=1; RUN->OUT on the cycle core_busy_i=0, capturing R=core_data_i into the output register.
REQ-015 The captured result SHALL be R for ECB; R for CBC encrypt, with chain<=R; R^chain for CBC decrypt, with chain<=the ciphertext block loaded in LOAD.
REQ-016 In OUT, out_valid_o=1 and out_last_o equals the block's last bit; on out_ready_i the FSM SHALL go to LOAD if the FIFO is non-empty, else to IDLE; a push in the same cycle SHALL count as non-empty only from the next cycle.
REQ-017 A cycle counter SHALL clear on LOAD and increment in WAIT and RUN; on reaching TIMEOUT the FSM SHALL go to ERR with error_o=1.
REQ-018 ERR SHALL be terminal until reset: in_ready_o=0, out_valid_o=0.
REQ-019 Best-case latency from pop to out_valid_o SHALL be 3 cycles plus the core busy duration.

Reset
REQ-020 On rst_n=0, asynchronously: FSM to IDLE, FIFO empty, in_ready_o=1 only after reset deasserts (0 during reset), all outputs 0, error_o=0, chain and shadow registers 0, start-of-message flag set.
REQ-021 A reset mid-message SHALL discard all queued and in-flight blocks with no partial output.

Structure
REQ-022 A shared package aes_seq_pkg SHALL hold the state enum, the key-size codes and the 128/256 width constants.
REQ-023 The FIFO SHALL be one sub-module, aes_seq_fifo, parameterised by DEPTH and width.

Verification
REQ-024 ECB with key 2b7e151628aed2a6abf7158809cf4f3c, size 0, in 6bc1bee22e409f96e93d7e117393172a -> out 3ad77bb40d7a3660a89ecaf32466ef97, last=1.
REQ-025 CBC encrypt with the same key, IV 000102030405060708090a0b0c0d0e0f, same block -> 7649abac8119b246cee98e9b12e9197d; a second block chains on it.
REQ-026 CBC decrypt of 7649abac8119b246cee98e9b12e9197d with the same IV -> 6bc1bee22e409f96e93d7e117393172a.
REQ-027 Push DEPTH+1 blocks with out_ready_i=0 -> in_ready_o falls after DEPTH accepted; all blocks emerge in order once ready.
REQ-028 Core model holds busy low for TIMEOUT cycles -> error_o=1, in_ready_o=0 until rst_n pulse.
REQ-029 Assert rst_n=0 during RUN -> all outputs 0 immediately, no output block afterwards, next message uses fresh IV.
